// File: rtl/vga_stream_out.sv
`default_nettype none
// ============================================================================
// Module  : vga_stream_out
// Brief   : Pixel-clock VGA scanout stage fed by a valid/ready pixel stream.
//           Define VGA_STREAM_OUT_ERR_COUNT_EN to build the underflow counter.
// Rev     : 1.0  initial release
// ============================================================================
module vga_stream_out #(
  parameter int COLOR_WIDTH = 4,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic                   pixel_clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   s_pix_valid,
  output logic                   s_pix_ready,
  input  logic [COLOR_WIDTH-1:0] s_pix_red,
  input  logic [COLOR_WIDTH-1:0] s_pix_grn,
  input  logic [COLOR_WIDTH-1:0] s_pix_blu,
  output logic [COLOR_WIDTH-1:0] vga_red,
  output logic [COLOR_WIDTH-1:0] vga_grn,
  output logic [COLOR_WIDTH-1:0] vga_blu,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_error,
  output logic [15:0]            err_count
);

  localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);
  localparam int c_hx      = c_hw + 1;
  localparam int c_vx      = c_vw + 1;

  localparam logic [c_hw-1:0] c_h_last = c_hw'(c_h_total - 1);
  localparam logic [c_vw-1:0] c_v_last = c_vw'(c_v_total - 1);
  // One extra bit so a range end equal to the total never truncates.
  localparam logic [c_hx-1:0] c_h_vis  = c_hx'(H_VISIBLE);
  localparam logic [c_hx-1:0] c_hs_beg = c_hx'(H_VISIBLE + H_FRONT);
  localparam logic [c_hx-1:0] c_hs_end = c_hx'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [c_vx-1:0] c_v_vis  = c_vx'(V_VISIBLE);
  localparam logic [c_vx-1:0] c_vs_beg = c_vx'(V_VISIBLE + V_FRONT);
  localparam logic [c_vx-1:0] c_vs_end = c_vx'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_hw-1:0] r_h;
  logic [c_hw-1:0] w_h_nxt;
  logic [c_vw-1:0] r_v;
  logic [c_vw-1:0] w_v_nxt;

  logic w_run;
  logic w_visible;
  logic w_xfer;
  logic w_underflow;
  logic w_hs_act;
  logic w_vs_act;

  assign w_run       = (r_state == ST_RUN);
  assign w_visible   = w_run && ({1'b0, r_h} < c_h_vis) && ({1'b0, r_v} < c_v_vis);
  assign w_xfer      = w_visible && s_pix_valid;
  assign w_underflow = w_visible && !s_pix_valid;
  assign w_hs_act    = w_run && ({1'b0, r_h} >= c_hs_beg) && ({1'b0, r_h} < c_hs_end);
  assign w_vs_act    = w_run && ({1'b0, r_v} >= c_vs_beg) && ({1'b0, r_v} < c_vs_end);
  assign s_pix_ready = w_visible;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_v_nxt     = r_v;
    case (r_state)
      ST_IDLE: begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (en) w_state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        // The first valid pixel only starts the raster; it is taken at h = 0.
        if (s_pix_valid) begin
          w_state_nxt = ST_RUN;
          w_h_nxt     = '0;
          w_v_nxt     = '0;
        end
      end
      ST_RUN: begin
        if (r_h == c_h_last) begin
          w_h_nxt = '0;
          if (r_v == c_v_last) begin
            w_v_nxt = '0;
            if (!en) w_state_nxt = ST_IDLE;
          end else begin
            w_v_nxt = r_v + c_vw'(1);
          end
        end else begin
          w_h_nxt = r_h + c_hw'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      vga_red   <= '0;
      vga_grn   <= '0;
      vga_blu   <= '0;
      vga_hsync <= ~SYNC_POL;
      vga_vsync <= ~SYNC_POL;
      vga_error <= 1'b0;
    end else begin
      vga_red   <= w_xfer ? s_pix_red : '0;
      vga_grn   <= w_xfer ? s_pix_grn : '0;
      vga_blu   <= w_xfer ? s_pix_blu : '0;
      vga_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      vga_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      vga_error <= w_underflow;
    end
  end

`ifdef VGA_STREAM_OUT_ERR_COUNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_underflow && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_out.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_stream_out
// Brief   : Self-checking bench for vga_stream_out on a reduced 8x6 raster.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vga_stream_out;

  localparam int CW = 4;
  localparam int HV = 4, HF = 1, HS = 2, HB = 1;
  localparam int VV = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;

  logic          pixel_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          s_pix_valid = 1'b0;
  logic          s_pix_ready;
  logic [CW-1:0] s_pix_red = '0;
  logic [CW-1:0] s_pix_grn = '0;
  logic [CW-1:0] s_pix_blu = '0;
  logic [CW-1:0] vga_red, vga_grn, vga_blu;
  logic          vga_hsync, vga_vsync, vga_error;
  logic [15:0]   err_count;

  always #5 pixel_clk = ~pixel_clk;

  vga_stream_out #(
    .COLOR_WIDTH(CW),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
    .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .s_pix_red(s_pix_red), .s_pix_grn(s_pix_grn), .s_pix_blu(s_pix_blu),
    .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_error(vga_error),
    .err_count(err_count)
  );

  // Reference model: raster position kept as a linear pixel index in the frame.
  int            mode = M_IDLE;
  int            pos = 0;
  bit            started = 1'b0;
  logic [CW-1:0] e_red = '0, e_grn = '0, e_blu = '0;
  logic          e_hs = 1'b1, e_vs = 1'b1, e_err = 1'b0;
  logic [15:0]   e_cnt = '0;
  logic [7:0]    xlog[$];

  always @(posedge pixel_clk) begin
    int h;
    int v;
    bit vis;
    started = 1'b1;
    if (!rst_n) begin
      mode = M_IDLE; pos = 0;
      e_red = '0; e_grn = '0; e_blu = '0;
      e_hs = 1'b1; e_vs = 1'b1; e_err = 1'b0; e_cnt = '0;
    end else begin
      h   = pos % HT;
      v   = pos / HT;
      vis = (mode == M_RUN) && (h < HV) && (v < VV);
      e_red = (vis && s_pix_valid) ? s_pix_red : '0;
      e_grn = (vis && s_pix_valid) ? s_pix_grn : '0;
      e_blu = (vis && s_pix_valid) ? s_pix_blu : '0;
      e_hs  = !((mode == M_RUN) && (h >= HV + HF) && (h < HV + HF + HS));
      e_vs  = !((mode == M_RUN) && (v >= VV + VF) && (v < VV + VF + VS));
      e_err = vis && !s_pix_valid;
`ifdef VGA_STREAM_OUT_ERR_COUNT_EN
      if (e_err && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
`endif
      if (vis && s_pix_valid) xlog.push_back({s_pix_grn, s_pix_red});
      case (mode)
        M_IDLE:  if (en) mode = M_PRIME;
        M_PRIME: if (s_pix_valid) begin mode = M_RUN; pos = 0; end
        default: begin
          if (pos == HT * VT - 1) begin
            pos = 0;
            if (!en) mode = M_IDLE;
          end else begin
            pos = pos + 1;
          end
        end
      endcase
    end
  end

  int         n_chk = 0;
  int         n_fail = 0;
  int         hs_low = 0, vs_low = 0, err_obs = 0;
  logic       rst_v = 1'b0, en_v = 1'b0, src_valid = 1'b0;
  logic [7:0] pix = 8'd1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_ready();
    return int'((mode == M_RUN) && (pos % HT < HV) && (pos / HT < VV));
  endfunction

  function automatic bit at_pos(input int h, input int v);
    return (mode == M_RUN) && (pos % HT == h) && (pos / HT == v);
  endfunction

  task automatic drive();
    rst_n       = rst_v;
    en          = en_v;
    s_pix_valid = src_valid;
    s_pix_red   = pix[3:0];
    s_pix_grn   = pix[7:4];
    s_pix_blu   = ~pix[3:0];
  endtask

  // One clock: compare on the falling edge, then drive the next inputs.
  task automatic cycle();
    logic fire;
    @(negedge pixel_clk);
    if (started) begin
      chk("red",       int'(vga_red),     int'(e_red));
      chk("grn",       int'(vga_grn),     int'(e_grn));
      chk("blu",       int'(vga_blu),     int'(e_blu));
      chk("hsync",     int'(vga_hsync),   int'(e_hs));
      chk("vsync",     int'(vga_vsync),   int'(e_vs));
      chk("error",     int'(vga_error),   int'(e_err));
      chk("ready",     int'(s_pix_ready), exp_ready());
      chk("err_count", int'(err_count),   int'(e_cnt));
      if (!vga_hsync) hs_low++;
      if (!vga_vsync) vs_low++;
      if (vga_error)  err_obs++;
    end
    fire = s_pix_valid && s_pix_ready && rst_n;
    @(posedge pixel_clk);
    #1;
    if (fire) pix = pix + 8'd1;
    drive();
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!at_pos(h, v) && n < 500);
    if (!at_pos(h, v)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_pos(%0d,%0d): got timeout expected position", h, v);
    end
  endtask

  initial begin
    int hs0, vs0, er0, n;
    drive();
    repeat (3) cycle();
    rst_v = 1'b1;
    repeat (20) cycle();
    chk("idle_hsync", int'(vga_hsync),   1);
    chk("idle_vsync", int'(vga_vsync),   1);
    chk("idle_ready", int'(s_pix_ready), 0);
    chk("idle_red",   int'(vga_red),     0);

    // Frame 1: continuous stream.
    en_v = 1'b1; src_valid = 1'b1;
    wait_pos(0, 0);
    hs0 = hs_low; vs0 = vs_low; er0 = err_obs;
    wait_pos(0, 0);
    chk("f1_xfers", xlog.size(), 12);
    chk("f1_pix0", int'(xlog[0]), 1);
    chk("f1_pix1", int'(xlog[1]), 2);
    chk("f1_pix2", int'(xlog[2]), 3);
    chk("f1_pix3", int'(xlog[3]), 4);
    chk("f1_hs_low", hs_low - hs0, 12);
    chk("f1_vs_low", vs_low - vs0, 8);
    chk("f1_errors", err_obs - er0, 0);

    // Frame 2: two-cycle starvation at h = 2, 3 on line 1, then backpressure.
    er0 = err_obs;
    wait_pos(1, 1);
    src_valid = 1'b0;
    cycle();
    cycle();
    src_valid = 1'b1;
    wait_pos(5, 1);
    chk("bp_ready", int'(s_pix_ready), 0);
    wait_pos(0, 0);
    chk("f2_xfers", xlog.size() - 12, 10);
    chk("f2_held_pix", int'(xlog[18]), 19);
    chk("f2_errors", err_obs - er0, 2);
`ifdef VGA_STREAM_OUT_ERR_COUNT_EN
    chk("f2_err_count", int'(err_count), 2);
`else
    chk("f2_err_count", int'(err_count), 0);
`endif

    // Frame 3: stop request mid-frame takes effect only at frame end.
    wait_pos(2, 2);
    en_v = 1'b0;
    cycle();
    n = 0;
    while (mode != M_IDLE && n < 200) begin
      cycle();
      n++;
    end
    chk("stop_latency", n, 29);
    cycle();
    chk("stop_hsync", int'(vga_hsync),   1);
    chk("stop_ready", int'(s_pix_ready), 0);

    // Restart without valid data: held in PRIME with blank output.
    en_v = 1'b1; src_valid = 1'b0;
    repeat (6) cycle();
    chk("prime_ready", int'(s_pix_ready), 0);
    chk("prime_red",   int'(vga_red),     0);
    chk("prime_hsync", int'(vga_hsync),   1);
    src_valid = 1'b1;
    wait_pos(0, 0);
    src_valid = 1'b0;
    cycle();
    src_valid = 1'b1;
    wait_pos(1, 1);
`ifdef VGA_STREAM_OUT_ERR_COUNT_EN
    chk("pre_rst_err_count", int'(err_count), 3);
`else
    chk("pre_rst_err_count", int'(err_count), 0);
`endif

    // Mid-frame reset asserted during h = 2, v = 1.
    rst_v = 1'b0;
    cycle();
    cycle();
    chk("rst_err_count", int'(err_count),   0);
    chk("rst_hsync",     int'(vga_hsync),   1);
    chk("rst_vsync",     int'(vga_vsync),   1);
    chk("rst_red",       int'(vga_red),     0);
    chk("rst_error",     int'(vga_error),   0);
    chk("rst_ready",     int'(s_pix_ready), 0);
    rst_v = 1'b1;
    repeat (5) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
